// File: rtl/bbox_frame_sched.sv
// Frame sequencer and pixel-RAM read-port arbiter for boundingBox; optional watchdog via BBOX_SCHED_TIMEOUT_EN.
// Latency: frame_ready->bb_start 1 cycle, bb_done->res_valid 1 cycle, host grant->host_ack 1 cycle.
// Backpressure: result held in PRESENT until res_ready; host requests wait while the engine owns the port.
module bbox_frame_sched #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 16,
    parameter int COORD_W        = 11,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               frame_ready,
    output logic               frame_release,
    output logic               bb_start,
    input  logic               bb_done,
    input  logic [ADDR_W-1:0]  bb_addr,
    output logic [DATA_W-1:0]  bb_rddata,
    input  logic [COORD_W-1:0] bb_xmin,
    input  logic [COORD_W-1:0] bb_xmax,
    input  logic [COORD_W-1:0] bb_ymin,
    input  logic [COORD_W-1:0] bb_ymax,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic [DATA_W-1:0]  mem_rddata,
    input  logic               host_req,
    input  logic [ADDR_W-1:0]  host_addr,
    output logic               host_ack,
    output logic [DATA_W-1:0]  host_rddata,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [COORD_W-1:0] res_xmin,
    output logic [COORD_W-1:0] res_xmax,
    output logic [COORD_W-1:0] res_ymin,
    output logic [COORD_W-1:0] res_ymax,
    output logic               res_empty,
    output logic               res_timeout,
    output logic               busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_RUN,
        S_PRESENT
    } state_t;

    state_t state, state_nxt;
    logic   host_grant;
    logic   capture;

`ifdef BBOX_SCHED_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wd_cnt;
    logic             timeout_hit;

    // Counter holds k-1 in the k-th RUN cycle, so the exit fires after exactly TIMEOUT_CYCLES RUN cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt <= '0;
        end else if (state == S_START) begin
            wd_cnt <= '0;
        end else if (state == S_RUN) begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end

    assign timeout_hit = (state == S_RUN) && !bb_done && (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        bb_start      = 1'b0;
        frame_release = 1'b0;
        res_valid     = 1'b0;
        capture       = 1'b0;
        host_grant    = 1'b0;
        mem_addr      = '0;
        bb_rddata     = '0;
        case (state)
            S_IDLE: begin
                // A waiting frame takes the port before the host.
                if (frame_ready) begin
                    state_nxt = S_START;
                end else begin
                    host_grant = host_req;
                end
            end
            S_START: begin
                bb_start  = 1'b1;
                state_nxt = S_RUN;
            end
            S_RUN: begin
                mem_addr  = bb_addr;
                bb_rddata = mem_rddata;
                if (bb_done) begin
                    capture   = 1'b1;
                    state_nxt = S_PRESENT;
                end
`ifdef BBOX_SCHED_TIMEOUT_EN
                else if (timeout_hit) begin
                    state_nxt = S_PRESENT;
                end
`endif
            end
            S_PRESENT: begin
                res_valid  = 1'b1;
                host_grant = host_req;
                if (res_ready) begin
                    frame_release = 1'b1;
                    state_nxt     = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
        if (host_grant) begin
            mem_addr = host_addr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_xmin <= '0;
            res_xmax <= '0;
            res_ymin <= '0;
            res_ymax <= '0;
        end else if (capture) begin
            res_xmin <= bb_xmin;
            res_xmax <= bb_xmax;
            res_ymin <= bb_ymin;
            res_ymax <= bb_ymax;
        end
`ifdef BBOX_SCHED_TIMEOUT_EN
        else if (timeout_hit) begin
            res_xmin <= '1;
            res_xmax <= '1;
            res_ymin <= '1;
            res_ymax <= '1;
        end
`endif
    end

`ifdef BBOX_SCHED_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_timeout <= 1'b0;
        end else if (capture) begin
            res_timeout <= 1'b0;
        end else if (timeout_hit) begin
            res_timeout <= 1'b1;
        end
    end
`else
    assign res_timeout = 1'b0;
`endif

    // RAM data for a granted host read arrives one cycle after the grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            host_ack <= 1'b0;
        end else begin
            host_ack <= host_grant;
        end
    end

    assign host_rddata = host_ack ? mem_rddata : '0;
    assign res_empty   = (res_xmin > res_xmax) || (res_ymin > res_ymax);
    assign busy        = (state != S_IDLE);

endmodule

// File: tb/tb_bbox_frame_sched.sv
// Directed bench for bbox_frame_sched: sequencing, arbitration, result hold, empty flag, reset abort, optional watchdog.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_bbox_frame_sched;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 16;
    localparam int COORD_W = 11;

    logic               clk;
    logic               rst_n;
    logic               frame_ready;
    logic               frame_release;
    logic               bb_start;
    logic               bb_done;
    logic [ADDR_W-1:0]  bb_addr;
    logic [DATA_W-1:0]  bb_rddata;
    logic [COORD_W-1:0] bb_xmin, bb_xmax, bb_ymin, bb_ymax;
    logic [ADDR_W-1:0]  mem_addr;
    logic [DATA_W-1:0]  mem_rddata;
    logic               host_req;
    logic [ADDR_W-1:0]  host_addr;
    logic               host_ack;
    logic [DATA_W-1:0]  host_rddata;
    logic               res_valid;
    logic               res_ready;
    logic [COORD_W-1:0] res_xmin, res_xmax, res_ymin, res_ymax;
    logic               res_empty;
    logic               res_timeout;
    logic               busy;

    logic [DATA_W-1:0]  ram [0:255];

    int tests = 0;
    int fails = 0;

    bbox_frame_sched #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .COORD_W(COORD_W),
        .TIMEOUT_CYCLES(100)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .frame_ready(frame_ready),
        .frame_release(frame_release),
        .bb_start(bb_start),
        .bb_done(bb_done),
        .bb_addr(bb_addr),
        .bb_rddata(bb_rddata),
        .bb_xmin(bb_xmin),
        .bb_xmax(bb_xmax),
        .bb_ymin(bb_ymin),
        .bb_ymax(bb_ymax),
        .mem_addr(mem_addr),
        .mem_rddata(mem_rddata),
        .host_req(host_req),
        .host_addr(host_addr),
        .host_ack(host_ack),
        .host_rddata(host_rddata),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .res_xmin(res_xmin),
        .res_xmax(res_xmax),
        .res_ymin(res_ymin),
        .res_ymax(res_ymax),
        .res_empty(res_empty),
        .res_timeout(res_timeout),
        .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Synchronous RAM, one-cycle read latency; contents {A5, addr} except a marked pixel at 0x10.
    always @(posedge clk) begin
        mem_rddata <= ram[mem_addr[7:0]];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            ram[i] = {8'hA5, 8'(i)};
        end
        ram[8'h10] = 16'h00FF;

        rst_n       = 1'b0;
        frame_ready = 1'b0;
        bb_done     = 1'b0;
        bb_addr     = '0;
        bb_xmin     = '0;
        bb_xmax     = '0;
        bb_ymin     = '0;
        bb_ymax     = '0;
        host_req    = 1'b0;
        host_addr   = '0;
        res_ready   = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_bb_start", 32'(bb_start), 32'd0);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_res_xmin", 32'(res_xmin), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_host_ack", 32'(host_ack), 32'd0);
        check("rst_frame_release", 32'(frame_release), 32'd0);
        check("rst_res_timeout", 32'(res_timeout), 32'd0);

        // Frame 1: normal result with a slow consumer and a host read deferred until PRESENT.
        rst_n       = 1'b1;
        frame_ready = 1'b1;
        #1 check("idle_no_start_yet", 32'(bb_start), 32'd0);
        @(negedge clk);
        check("start_pulse", 32'(bb_start), 32'd1);
        check("start_busy", 32'(busy), 32'd1);
        frame_ready = 1'b0;
        bb_addr     = 32'h10;
        @(negedge clk);
        check("run_start_low", 32'(bb_start), 32'd0);
        check("run_mem_addr", mem_addr, 32'h10);
        host_req  = 1'b1;
        host_addr = 32'h20;
        #1 check("run_host_not_granted", mem_addr, 32'h10);
        @(negedge clk);
        check("run_bb_rddata", 32'(bb_rddata), 32'h00FF);
        check("run_no_host_ack", 32'(host_ack), 32'd0);
        bb_done = 1'b1;
        bb_xmin = 11'd5;
        bb_xmax = 11'd120;
        bb_ymin = 11'd7;
        bb_ymax = 11'd90;
        @(negedge clk);
        check("pres_valid", 32'(res_valid), 32'd1);
        check("pres_xmin", 32'(res_xmin), 32'd5);
        check("pres_xmax", 32'(res_xmax), 32'd120);
        check("pres_ymin", 32'(res_ymin), 32'd7);
        check("pres_ymax", 32'(res_ymax), 32'd90);
        check("pres_empty", 32'(res_empty), 32'd0);
        check("pres_timeout", 32'(res_timeout), 32'd0);
        check("pres_host_ack_not_yet", 32'(host_ack), 32'd0);
        check("pres_host_granted", mem_addr, 32'h20);
        bb_done = 1'b0;
        bb_xmin = 11'd1;
        @(negedge clk);
        check("host_ack", 32'(host_ack), 32'd1);
        check("host_rddata", 32'(host_rddata), 32'hA520);
        check("hold_valid_1", 32'(res_valid), 32'd1);
        check("no_release_early", 32'(frame_release), 32'd0);
        host_req = 1'b0;
        @(negedge clk);
        check("host_ack_single", 32'(host_ack), 32'd0);
        check("hold_xmin", 32'(res_xmin), 32'd5);
        @(negedge clk);
        check("hold_valid_4", 32'(res_valid), 32'd1);
        res_ready = 1'b1;
        #1 check("release_pulse", 32'(frame_release), 32'd1);
        @(negedge clk);
        check("idle_valid_low", 32'(res_valid), 32'd0);
        check("idle_release_low", 32'(frame_release), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_keeps_xmax", 32'(res_xmax), 32'd120);

        // Frame 2: empty box; frame_ready stays high so the next frame starts at once and beats the host.
        res_ready   = 1'b0;
        frame_ready = 1'b1;
        @(negedge clk);
        check("f2_start", 32'(bb_start), 32'd1);
        @(negedge clk);
        bb_done = 1'b1;
        bb_xmin = 11'd2047;
        bb_xmax = 11'd0;
        bb_ymin = 11'd3;
        bb_ymax = 11'd4;
        @(negedge clk);
        check("f2_valid", 32'(res_valid), 32'd1);
        check("f2_empty", 32'(res_empty), 32'd1);
        check("f2_xmin", 32'(res_xmin), 32'h7FF);
        bb_done   = 1'b0;
        res_ready = 1'b1;
        #1 check("f2_release", 32'(frame_release), 32'd1);
        @(negedge clk);
        check("f2_idle_busy", 32'(busy), 32'd0);
        res_ready = 1'b0;
        host_req  = 1'b1;
        host_addr = 32'h30;
        #1 check("frame_beats_host", mem_addr, 32'd0);
        @(negedge clk);
        check("f3_restart", 32'(bb_start), 32'd1);
        check("f3_no_host_ack", 32'(host_ack), 32'd0);
        frame_ready = 1'b0;
        host_req    = 1'b0;
        @(negedge clk);
        bb_addr = 32'h5;
        #1 check("f3_run_mem_addr", mem_addr, 32'h5);

        // Asynchronous reset in the middle of RUN.
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_valid", 32'(res_valid), 32'd0);
        check("abort_xmin", 32'(res_xmin), 32'd0);
        check("abort_ymax", 32'(res_ymax), 32'd0);
        check("abort_empty", 32'(res_empty), 32'd0);
        check("abort_mem_addr", mem_addr, 32'd0);
        check("abort_bb_rddata", 32'(bb_rddata), 32'd0);
        check("abort_release", 32'(frame_release), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_abort_busy", 32'(busy), 32'd0);
        check("post_abort_release", 32'(frame_release), 32'd0);
        frame_ready = 1'b1;
        @(negedge clk);
        check("post_abort_start", 32'(bb_start), 32'd1);
        frame_ready = 1'b0;
        @(negedge clk);
        bb_done   = 1'b1;
        bb_xmin   = 11'd1;
        bb_xmax   = 11'd2;
        bb_ymin   = 11'd3;
        bb_ymax   = 11'd4;
        res_ready = 1'b1;
        @(negedge clk);
        check("f4_valid", 32'(res_valid), 32'd1);
        check("f4_xmin", 32'(res_xmin), 32'd1);
        check("f4_ymax", 32'(res_ymax), 32'd4);
        check("f4_release_1cyc_present", 32'(frame_release), 32'd1);
        bb_done = 1'b0;
        @(negedge clk);
        check("f4_valid_low", 32'(res_valid), 32'd0);
        bb_done = 1'b1;
        bb_xmin = 11'd9;
        @(negedge clk);
        check("done_ignored_idle_busy", 32'(busy), 32'd0);
        check("done_ignored_idle_xmin", 32'(res_xmin), 32'd1);
        bb_done   = 1'b0;
        res_ready = 1'b0;

`ifdef BBOX_SCHED_TIMEOUT_EN
        // Watchdog: no bb_done, PRESENT after exactly 100 RUN cycles.
        frame_ready = 1'b1;
        @(negedge clk);
        check("wd_start", 32'(bb_start), 32'd1);
        frame_ready = 1'b0;
        repeat (100) @(negedge clk);
        check("wd_still_run", 32'(res_valid), 32'd0);
        @(negedge clk);
        check("wd_valid", 32'(res_valid), 32'd1);
        check("wd_timeout", 32'(res_timeout), 32'd1);
        check("wd_xmin", 32'(res_xmin), 32'h7FF);
        check("wd_ymax", 32'(res_ymax), 32'h7FF);
        check("wd_empty", 32'(res_empty), 32'd0);
        res_ready = 1'b1;
        #1 check("wd_release", 32'(frame_release), 32'd1);
        @(negedge clk);
        check("wd_idle", 32'(res_valid), 32'd0);
        res_ready = 1'b0;
`else
        check("no_wd_timeout_low", 32'(res_timeout), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
